text_overlay_drawer: RTL and testbench
======================================

TEXT_OVERLAY_DRAWER -- requirements
Module: text_overlay_drawer

Interface
REQ-001 SHALL have parameter NUM_CHARS, default 5, characters per string.
REQ-002 SHALL have parameters X0/Y0, defaults 140/150, top-left pixel of char 0.
REQ-003 SHALL have parameters STEP_X/STEP_Y, defaults 80/55, per-character offset (diagonal layout allowed).
REQ-004 SHALL have parameters SCALE_X/SCALE_Y, defaults 8/7, screen pixels per glyph cell; CHAR_W=5*SCALE_X, CHAR_H=7*SCALE_Y.
REQ-005 Ports: Clock in 1, sole clock; Reset in 1, synchronous active-high reset.
REQ-006 Ports: cmd_valid in 1; cmd_ready out 1; cmd_op in 1 (0=DRAW, 1=ERASE); cmd_transparent in 1; cmd_color in 9; cmd_text in 4*NUM_CHARS (char i at bits [4i+3:4i]).
REQ-007 Ports: abort in 1, cancels the operation in progress.
REQ-008 Ports: glyph_addr out 7 ({code[3:0], row[2:0]}); glyph_bits in 5, combinational ROM reply in the same cycle, bit 4 = leftmost cell.
REQ-009 Ports: VGA_x out 10; VGA_y out 9; VGA_color out 9; VGA_write out 1; VGA_ready in 1, pixel sink ready.
REQ-010 Ports: busy out 1; done out 1, single-cycle completion pulse.

Function
REQ-011 States SHALL be IDLE, SCAN and FINISH.
REQ-012 IDLE: cmd_ready=1; on cmd_valid, capture cmd_op/transparent/color/text, zero the counters, go to SCAN.
REQ-013 cmd_ready SHALL be 0 outside IDLE; cmd_valid there SHALL be ignored.
REQ-014 Scan order: char 0..NUM_CHARS-1; within a char, py 0..CHAR_H-1 (outer), px 0..CHAR_W-1 (inner).
REQ-015 Cell mapping: gx=px/SCALE_X, gy=py/SCALE_Y; glyph_addr={code_i, gy}; on = glyph_bits[4-gx].
REQ-016 Pixel coordinates: VGA_x=(X0+i*STEP_X+px) mod 1024; VGA_y=(Y0+i*STEP_Y+py) mod 512 (wrap, no saturation).
REQ-017 Pixel colour: DRAW uses cmd_color if on, else 0. ERASE writes 0 for every pixel.
REQ-018 Transparent DRAW: off pixels SHALL NOT be written (VGA_write=0 that cycle); the counters still advance one pixel per cycle.
REQ-019 Transparent ERASE SHALL write 0 only where on=1 (glyph-shaped erase).
REQ-020 VGA_x/y/color/write SHALL be registered; the first pixel appears the cycle after command acceptance.
REQ-021 Backpressure: while VGA_write=1 and VGA_ready=0, all VGA outputs and counters SHALL hold.
REQ-022 Backpressure: a pixel is consumed on VGA_write&VGA_ready.
REQ-023 Backpressure: cycles with VGA_write=0 SHALL never stall.
REQ-024 Unstalled latency SHALL be exactly NUM_CHARS*CHAR_W*CHAR_H cycles from acceptance to last pixel presented.
REQ-025 After the last pixel is consumed (or skipped), the FSM SHALL go to FINISH with VGA_write=0.
REQ-026 FINISH: done=1 for exactly one cycle, then IDLE.
REQ-027 busy=1 in SCAN and FINISH; 0 in IDLE.
REQ-028 abort=1 in SCAN SHALL give VGA_write=0 and IDLE next cycle, with no done pulse; a held pixel is dropped. abort in IDLE/FINISH SHALL be ignored.
REQ-029 Counter widths SHALL cover CHAR_W, CHAR_H and NUM_CHARS without overflow for any legal parameters.
REQ-030 The text field SHALL be sampled only at acceptance; later cmd_text changes SHALL have no effect.

Reset
REQ-031 While Reset=1, the FSM SHALL enter IDLE.
REQ-032 Reset values: cmd_ready=0 during reset, 1 in the first IDLE cycle after; busy=0, done=0, VGA_write=0, VGA_x=0, VGA_y=0, VGA_color=0; counters 0.
REQ-033 Reset mid-SCAN SHALL abandon the operation the next edge with no done pulse and no further writes.

Verification (defaults; CHAR 40x49; glyph ROM model = 5x7 font)
REQ-034 DRAW "LANER", opaque, color 9'h1F8, VGA_ready=1: exactly 9800 writes, done 9801 cycles after accept, first write (140,150).
REQ-035 Same DRAW: char 4's first pixel at (460,370), last pixel at (499,418).
REQ-036 ERASE "LANER", transparent: writes = lit-cell count*56, all colour 0, no off pixels written, done after 9800 scan cycles.
REQ-037 Stall: VGA_ready=0 for 10 cycles at pixel 100: outputs frozen, pixel 100 repeated exactly once on release.
REQ-038 Stall: the same run completes 10 cycles later than REQ-034.
REQ-039 abort at pixel 500: VGA_write=0 next cycle, cmd_ready=1, no done.
REQ-040 Reset asserted mid-SCAN: all outputs match REQ-032 next edge.
REQ-041 Override X0=1000: x wraps to 0..15 within char 0 row.
REQ-042 cmd_valid during busy: ignored, capture registers unchanged.

Source files
------------

// File: rtl/text_overlay_drawer.sv
// Text overlay drawer: scans a string of 5x7 glyphs pixel by pixel and
// streams scaled pixels to a VGA pixel sink with valid/ready backpressure.
module text_overlay_drawer #(
   parameter int NUM_CHARS = 5,
   parameter int X0        = 140,
   parameter int Y0        = 150,
   parameter int STEP_X    = 80,
   parameter int STEP_Y    = 55,
   parameter int SCALE_X   = 8,
   parameter int SCALE_Y   = 7
) (
   input  logic                   Clock,
   input  logic                   Reset,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic                   cmd_op,
   input  logic                   cmd_transparent,
   input  logic [8:0]             cmd_color,
   input  logic [4*NUM_CHARS-1:0] cmd_text,
   input  logic                   abort,
   output logic [6:0]             glyph_addr,
   input  logic [4:0]             glyph_bits,
   output logic [9:0]             VGA_x,
   output logic [8:0]             VGA_y,
   output logic [8:0]             VGA_color,
   output logic                   VGA_write,
   input  logic                   VGA_ready,
   output logic                   busy,
   output logic                   done
);

   localparam int CHAR_W = 5 * SCALE_X;
   localparam int CHAR_H = 7 * SCALE_Y;
   localparam int CW  = $clog2(NUM_CHARS + 1);
   localparam int PXW = $clog2(CHAR_W + 1);
   localparam int PYW = $clog2(CHAR_H + 1);
   localparam int SXW = $clog2(SCALE_X + 1);
   localparam int SYW = $clog2(SCALE_Y + 1);
   localparam logic [9:0] X0V = 10'(X0 % 1024);
   localparam logic [8:0] Y0V = 9'(Y0 % 512);
   localparam logic [9:0] STX = 10'(STEP_X % 1024);
   localparam logic [8:0] STY = 9'(STEP_Y % 512);

   typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;

   state_t                   state;
   logic                     op_q, tr_q, last;
   logic [8:0]               color_q;
   logic [4*NUM_CHARS-1:0]   text_q;
   logic [CW-1:0]            ch;
   logic [PXW-1:0]           px;
   logic [PYW-1:0]           py;
   logic [SXW-1:0]           sx;
   logic [SYW-1:0]           sy;
   logic [2:0]               gx, gy;
   logic [9:0]               base_x;
   logic [8:0]               base_y;

   logic       idle, on, s_op, s_tr, pix_w, stall, step, clr;
   logic       fin_px, fin_py, fin_ch, is_final;
   logic [3:0] code;
   logic [8:0] s_color, pix_c;
   logic [9:0] pix_x;
   logic [8:0] pix_y;

   // In IDLE the pixel about to be loaded comes straight from the command.
   always_comb begin
      idle     = (state == IDLE);
      code     = idle ? cmd_text[3:0] : text_q[4*int'(ch) +: 4];
      s_op     = idle ? cmd_op : op_q;
      s_tr     = idle ? cmd_transparent : tr_q;
      s_color  = idle ? cmd_color : color_q;
      on       = glyph_bits[3'd4 - gx];
      pix_w    = !s_tr || on;
      pix_c    = (!s_op && on) ? s_color : 9'd0;
      pix_x    = base_x + 10'(px);
      pix_y    = base_y + 9'(py);
      fin_px   = (px == PXW'(CHAR_W - 1));
      fin_py   = (py == PYW'(CHAR_H - 1));
      fin_ch   = (ch == CW'(NUM_CHARS - 1));
      is_final = fin_px && fin_py && fin_ch;
      stall    = VGA_write && !VGA_ready;
      step     = (idle && cmd_valid) ||
                 (state == SCAN && !abort && !stall && !last);
      clr      = (state == SCAN) && (abort || (!stall && last));
   end

   assign glyph_addr = {code, gy};
   assign cmd_ready  = idle && !Reset;
   assign busy       = !idle;
   assign done       = (state == FINISH);

   // Counters always hold the pixel to be loaded on the next unstalled edge.
   always_ff @(posedge Clock) begin
      if (Reset || clr) begin
         ch <= '0; px <= '0; py <= '0;
         sx <= '0; sy <= '0; gx <= '0; gy <= '0;
         base_x <= X0V;
         base_y <= Y0V;
      end else if (step && !is_final) begin
         if (!fin_px) begin
            px <= px + 1'b1;
            if (sx == SXW'(SCALE_X - 1)) begin
               sx <= '0;
               gx <= gx + 1'b1;
            end else begin
               sx <= sx + 1'b1;
            end
         end else begin
            px <= '0; sx <= '0; gx <= '0;
            if (!fin_py) begin
               py <= py + 1'b1;
               if (sy == SYW'(SCALE_Y - 1)) begin
                  sy <= '0;
                  gy <= gy + 1'b1;
               end else begin
                  sy <= sy + 1'b1;
               end
            end else begin
               py <= '0; sy <= '0; gy <= '0;
               ch <= ch + 1'b1;
               base_x <= base_x + STX;
               base_y <= base_y + STY;
            end
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state     <= IDLE;
         op_q      <= 1'b0;
         tr_q      <= 1'b0;
         color_q   <= '0;
         text_q    <= '0;
         last      <= 1'b0;
         VGA_x     <= '0;
         VGA_y     <= '0;
         VGA_color <= '0;
         VGA_write <= 1'b0;
      end else begin
         unique case (state)
            IDLE: if (cmd_valid) begin
               op_q      <= cmd_op;
               tr_q      <= cmd_transparent;
               color_q   <= cmd_color;
               text_q    <= cmd_text;
               VGA_x     <= pix_x;
               VGA_y     <= pix_y;
               VGA_color <= pix_c;
               VGA_write <= pix_w;
               last      <= is_final;
               state     <= SCAN;
            end
            SCAN: if (abort) begin
               VGA_write <= 1'b0;
               last      <= 1'b0;
               state     <= IDLE;
            end else if (!stall) begin
               if (last) begin
                  VGA_write <= 1'b0;
                  last      <= 1'b0;
                  state     <= FINISH;
               end else begin
                  VGA_x     <= pix_x;
                  VGA_y     <= pix_y;
                  VGA_color <= pix_c;
                  VGA_write <= pix_w;
                  last      <= is_final;
               end
            end
            FINISH: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_text_overlay_drawer.sv
// Bench for text_overlay_drawer: random and directed commands checked
// against a pixel-list model of the glyph scan.
module tb_text_overlay_drawer;

   localparam int NC = 5;
   localparam int SX = 8;
   localparam int SY = 7;
   localparam int CW = 5 * SX;
   localparam int CH = 7 * SY;
   localparam int N  = NC * CW * CH;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        Reset, cmd_valid, cmd_ready, cmd_op, cmd_transparent, abort;
   logic [8:0]  cmd_color;
   logic [19:0] cmd_text;
   logic [6:0]  glyph_addr;
   logic [4:0]  glyph_bits;
   logic [9:0]  VGA_x;
   logic [8:0]  VGA_y, VGA_color;
   logic        VGA_write, VGA_ready, busy, done;

   logic [4:0]  rom [0:127];
   assign glyph_bits = rom[glyph_addr];

   text_overlay_drawer dut (
      .Clock(clk), .Reset(Reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_transparent(cmd_transparent),
      .cmd_color(cmd_color), .cmd_text(cmd_text), .abort(abort),
      .glyph_addr(glyph_addr), .glyph_bits(glyph_bits),
      .VGA_x(VGA_x), .VGA_y(VGA_y), .VGA_color(VGA_color),
      .VGA_write(VGA_write), .VGA_ready(VGA_ready),
      .busy(busy), .done(done)
   );

   logic       w_valid, w_rdy, w_abort, w_sink, w_wr, w_busy, w_done;
   logic [3:0] w_text;
   logic [6:0] w_ga;
   logic [4:0] w_gb;
   logic [9:0] w_x;
   logic [8:0] w_y, w_c;
   assign w_gb = rom[w_ga];

   text_overlay_drawer #(.NUM_CHARS(1), .X0(1000), .Y0(500)) u_wrap (
      .Clock(clk), .Reset(Reset),
      .cmd_valid(w_valid), .cmd_ready(w_rdy),
      .cmd_op(1'b0), .cmd_transparent(1'b0),
      .cmd_color(9'h123), .cmd_text(w_text), .abort(w_abort),
      .glyph_addr(w_ga), .glyph_bits(w_gb),
      .VGA_x(w_x), .VGA_y(w_y), .VGA_color(w_c),
      .VGA_write(w_wr), .VGA_ready(w_sink),
      .busy(w_busy), .done(w_done)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   logic [27:0] exp_q [$];

   // Expected written pixels, in scan order, straight from the layout rules.
   task automatic build(input bit op, input bit tr, input logic [8:0] col,
                        input logic [19:0] txt, input int x0, input int y0,
                        input int nc);
      int code, xx, yy;
      logic [4:0] row;
      logic [8:0] c;
      bit on;
      exp_q.delete();
      for (int i = 0; i < nc; i++)
         for (int py = 0; py < CH; py++)
            for (int px = 0; px < CW; px++) begin
               code = int'(txt[4*i +: 4]);
               row  = rom[code*8 + py/SY];
               on   = row[4 - px/SX];
               xx   = (x0 + i*80 + px) % 1024;
               yy   = (y0 + i*55 + py) % 512;
               c    = (!op && on) ? col : 9'd0;
               if (!tr || on)
                  exp_q.push_back({10'(xx), 9'(yy), c});
            end
   endtask

   task automatic run(input string nm, input bit op, input bit tr,
                      input logic [8:0] col, input logic [19:0] txt,
                      input int stall_at, input bit rnd, input int abort_at,
                      input int rst_at, input bit abort_idle);
      int c, consumed, stalls, stall_left, n_exp;
      bit fin, stalled_once, got_done;
      build(op, tr, col, txt, 140, 150, NC);
      n_exp = exp_q.size();
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_op = op; cmd_transparent = tr;
      cmd_color = col; cmd_text = txt; VGA_ready = 1'b1; abort = abort_idle;
      @(negedge clk);
      chk({nm, "/idle_ready"}, cmd_ready, 1);
      chk({nm, "/idle_busy"}, busy, 0);
      @(posedge clk); #1;
      cmd_valid = 1'b0; abort = 1'b0;
      c = 1; consumed = 0; stalls = 0; stall_left = 0;
      fin = 0; stalled_once = 0; got_done = 0;
      while (!fin) begin
         if (stall_left > 0) begin
            VGA_ready = 1'b0;
            stall_left--;
         end else begin
            VGA_ready = rnd ? ($urandom_range(3) != 0) : 1'b1;
         end
         if (c < 200) begin
            cmd_valid = 1'($urandom); cmd_op = 1'($urandom);
            cmd_transparent = 1'($urandom);
            cmd_color = 9'($urandom); cmd_text = 20'($urandom);
         end else begin
            cmd_valid = 1'b0;
         end
         @(negedge clk);
         if (c == 1) begin
            chk({nm, "/scan_busy"}, busy, 1);
            chk({nm, "/scan_ready"}, cmd_ready, 0);
         end
         if (done) begin
            chk({nm, "/done_cycle"}, c, N + 1 + stalls);
            chk({nm, "/writes"}, consumed, n_exp);
            chk({nm, "/left"}, exp_q.size(), 0);
            if (stall_at >= 0) chk({nm, "/stall_cnt"}, stalls, 10);
            fin = 1; got_done = 1;
         end else if (VGA_write) begin
            if (exp_q.size() == 0) begin
               chk({nm, "/extra_write"}, VGA_write, 0);
               fin = 1;
            end else if (VGA_ready) begin
               chk({nm, "/pix"}, {VGA_x, VGA_y, VGA_color}, exp_q.pop_front());
               consumed++;
            end else begin
               chk({nm, "/hold"}, {VGA_x, VGA_y, VGA_color}, exp_q[0]);
               stalls++;
            end
         end
         if (!fin) begin
            if (consumed == stall_at && !stalled_once) begin
               stall_left = 10;
               stalled_once = 1;
            end
            if (consumed == abort_at || consumed == rst_at) fin = 1;
            if (c > 2 * N) begin
               chk({nm, "/timeout"}, c, N + 1);
               fin = 1;
            end
         end
         if (!fin) begin
            @(posedge clk); #1;
            c++;
         end
      end
      if (got_done) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk({nm, "/post_done"}, {done, cmd_ready, busy, VGA_write}, 4'b0100);
      end else if (abort_at >= 0 && consumed == abort_at) begin
         @(posedge clk); #1;
         abort = 1'b1; VGA_ready = 1'b1;
         @(negedge clk);
         chk({nm, "/abort_pix"}, {VGA_x, VGA_y, VGA_color}, exp_q[0]);
         @(posedge clk); #1;
         abort = 1'b0;
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk({nm, "/after_abort"},
                {done, cmd_ready, busy, VGA_write}, 4'b0100);
            @(posedge clk); #1;
         end
      end else if (rst_at >= 0 && consumed == rst_at) begin
         @(posedge clk); #1;
         Reset = 1'b1;
         @(negedge clk);
         chk({nm, "/rst_ready"}, cmd_ready, 0);
         @(posedge clk); #1;
         @(negedge clk);
         chk({nm, "/rst_outs"},
             {VGA_write, VGA_x, VGA_y, VGA_color, busy, done, cmd_ready}, 0);
         @(posedge clk); #1;
         Reset = 1'b0;
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk({nm, "/after_rst"},
                {done, cmd_ready, busy, VGA_write}, 4'b0100);
            @(posedge clk); #1;
         end
      end
   endtask

   localparam logic [19:0] LANER = {4'd5, 4'd2, 4'd4, 4'd1, 4'd3};

   initial begin
      for (int i = 0; i < 128; i++) rom[i] = 5'($urandom);
      // A=1 E=2 L=3 N=4 R=5
      {rom[8], rom[9], rom[10], rom[11], rom[12], rom[13], rom[14]} =
         {5'b01110, 5'b10001, 5'b10001, 5'b11111, 5'b10001, 5'b10001, 5'b10001};
      {rom[16], rom[17], rom[18], rom[19], rom[20], rom[21], rom[22]} =
         {5'b11111, 5'b10000, 5'b10000, 5'b11110, 5'b10000, 5'b10000, 5'b11111};
      {rom[24], rom[25], rom[26], rom[27], rom[28], rom[29], rom[30]} =
         {5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b11111};
      {rom[32], rom[33], rom[34], rom[35], rom[36], rom[37], rom[38]} =
         {5'b10001, 5'b11001, 5'b10101, 5'b10011, 5'b10001, 5'b10001, 5'b10001};
      {rom[40], rom[41], rom[42], rom[43], rom[44], rom[45], rom[46]} =
         {5'b11110, 5'b10001, 5'b10001, 5'b11110, 5'b10100, 5'b10010, 5'b10001};

      Reset = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_transparent = 1'b0;
      cmd_color = '0; cmd_text = '0; abort = 1'b0; VGA_ready = 1'b1;
      w_valid = 1'b0; w_abort = 1'b0; w_sink = 1'b1; w_text = 4'd3;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outs",
          {VGA_write, VGA_x, VGA_y, VGA_color, busy, done, cmd_ready}, 0);
      @(posedge clk); #1;
      Reset = 1'b0;
      @(negedge clk);
      chk("first_idle", {cmd_ready, busy, done}, 3'b100);

      run("draw", 1'b0, 1'b0, 9'h1F8, LANER, -1, 1'b0, -1, -1, 1'b0);
      run("erase_tr", 1'b1, 1'b1, 9'h1FF, LANER, -1, 1'b0, -1, -1, 1'b1);
      run("stall", 1'b0, 1'b0, 9'h1F8, LANER, 100, 1'b0, -1, -1, 1'b0);
      run("abort", 1'b0, 1'b0, 9'h055, LANER, -1, 1'b0, 500, -1, 1'b0);
      run("reset", 1'b0, 1'b0, 9'h0AA, LANER, -1, 1'b0, -1, 300, 1'b0);
      run("random", 1'($urandom), 1'($urandom), 9'($urandom),
          20'($urandom), -1, 1'b1, -1, -1, 1'b0);

      build(1'b0, 1'b0, 9'h123, {16'd0, w_text}, 1000, 500, 1);
      @(posedge clk); #1;
      w_valid = 1'b1;
      @(posedge clk); #1;
      w_valid = 1'b0;
      for (int k = 0; k < CW * CH; k++) begin
         @(negedge clk);
         chk("wrap_pix", {w_wr, w_x, w_y, w_c}, {1'b1, exp_q.pop_front()});
      end
      @(negedge clk);
      chk("wrap_done", {w_done, w_wr}, 2'b10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
